// File: rtl/pixel_stream_source.sv
// pixel_stream_source: streams one IMG_W x IMG_H frame from a frame buffer
// in raster order, in response to a one-cycle start request.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           one-cycle request to stream a frame (honoured in IDLE only)
//   stall           downstream cannot accept the presented pixel this cycle
//   mem_rd/mem_addr registered read strobe and linear read address
//   mem_data        RGB444 read data, valid the cycle after mem_rd
//   pixel_out       presented RGB444 pixel (head of a 2-entry FIFO)
//   out_ready       pixel_out is valid; a transfer happens when stall=0
//   sof/eol/eof     position flags of the presented pixel
//   busy/done       frame in progress / one-cycle end-of-frame pulse
module pixel_stream_source #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_data,
  output logic [11:0]       pixel_out,
  output logic              out_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = ADDR_W + 1;
  localparam int unsigned XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PW   = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     addr_q, addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              go_run;
  logic              issue;
  logic [2:0]        occ;

  // A transfer depends only on registered out_ready and the stall input.
  assign xfer   = rdy_q & ~stall;
  assign go_run = (state_q == S_IDLE) & start;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (xfer && eof_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Read issue. Every read already committed (in FIFO, strobed, or returning
  // now) must have a slot even if stall never drops, so the total is capped at 2.
  always_comb begin
    occ        = 3'(cnt_q) + 3'(mem_rd_q) + 3'(rd_vld_q) - 3'(xfer);
    issue      = (state_q == S_RUN) && (addr_q < CW'(NPIX)) && (occ < 3'd2);
    mem_rd_d   = issue;
    mem_addr_d = mem_addr_q;
    addr_d     = addr_q;
    rd_vld_d   = mem_rd_q;
    if (go_run) begin
      addr_d = '0;
    end else if (issue) begin
      mem_addr_d = addr_q[ADDR_W-1:0];
      addr_d     = addr_q + CW'(1);
    end
  end

  // 2-entry FIFO; head_q is the presented pixel and only moves on a transfer
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + 2'(rd_vld_q) - 2'(xfer);
    unique case (cnt_q)
      2'd0: begin
        if (rd_vld_q) head_d = mem_data;
      end
      2'd1: begin
        if (rd_vld_q && xfer)  head_d = mem_data;
        else if (rd_vld_q)     tail_d = mem_data;
      end
      2'd2: begin
        if (xfer) begin
          head_d = tail_q;
          if (rd_vld_q) tail_d = mem_data;
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Raster position of the presented pixel and its qualified flags
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (go_run) begin
      x_d = '0;
      y_d = '0;
    end else if (xfer) begin
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    rdy_d = (cnt_d != 2'd0);
    sof_d = rdy_d && (x_d == '0) && (y_d == '0);
    eol_d = rdy_d && (x_d == XW'(IMG_W - 1));
    eof_d = eol_d && (y_d == YW'(IMG_H - 1));
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      rd_vld_q   <= rd_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign pixel_out = head_q;
  assign out_ready = rdy_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Testbench for pixel_stream_source on a 4x3 frame; memory word n = 12'h100+n.
module tb_pixel_stream_source;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int          NPIX   = IMG_W * IMG_H;
  localparam int          BUDGET = 400;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stall;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data;
  logic [11:0]       pixel_out;
  logic              out_ready;
  logic              sof;
  logic              eol;
  logic              eof;
  logic              busy;
  logic              done;

  int n_chk;
  int n_pass;
  int seed_val;

  pixel_stream_source #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .pixel_out (pixel_out),
    .out_ready (out_ready),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer model: one-cycle read latency, junk on the bus otherwise
  always @(posedge clk) begin
    mem_data <= mem_rd ? (12'h100 + 12'(mem_addr)) : 12'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: no stall, 1: 5-cycle stall on pixel 5, 2: random stall,
  // 3: extra start at pixel 6, 4: stop after 7 transfers (caller resets)
  task automatic run_frame(input int mode, input bit start_in_done, input string tag);
    int          n;
    int          cyc;
    int          limit;
    int          stall_cnt;
    int          first_rd;
    int          first_rdy;
    int          done_cnt;
    bit          was_stalled;
    bit          start_sent;
    logic [14:0] held;
    n = 0; cyc = 0; stall_cnt = 0; first_rd = -1; first_rdy = -1; done_cnt = 0;
    was_stalled = 1'b0; start_sent = 1'b0; held = '0;
    limit = (mode == 4) ? 7 : NPIX;

    start = 1'b1;
    stall = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_busy_on_start"}, 32'(busy), 32'(1));

    while (n < limit && cyc < BUDGET) begin
      if (mem_rd && first_rd < 0) begin
        first_rd = cyc;
        check({tag, "_first_addr"}, 32'(mem_addr), 32'(0));
      end
      if (out_ready && first_rdy < 0) first_rdy = cyc;
      if (done) done_cnt++;
      if (was_stalled)
        check({tag, "_hold"}, 32'({out_ready, pixel_out, sof, eol, eof}), 32'({1'b1, held}));
      if (!out_ready)
        check({tag, "_flags_idle"}, 32'({sof, eol, eof}), 32'(0));

      if (mode == 1) begin
        if (n == 5 && out_ready && stall_cnt < 5) begin
          stall = 1'b1;
          stall_cnt++;
        end else begin
          stall = 1'b0;
        end
      end else if (mode == 2) begin
        stall = 1'($urandom_range(0, 1));
      end else begin
        stall = 1'b0;
      end

      start = (mode == 3) && (n == 6) && !start_sent;
      if (start) start_sent = 1'b1;

      if (mode == 1 && stall && stall_cnt >= 3)
        check({tag, "_rd_throttled"}, 32'(mem_rd), 32'(0));

      if (out_ready && !stall) begin
        check({tag, "_pixel"}, 32'(pixel_out), 32'(12'h100 + 12'(n)));
        check({tag, "_flags"}, 32'({sof, eol, eof}),
              32'({n == 0, (n % IMG_W) == IMG_W - 1, n == NPIX - 1}));
        n++;
      end
      was_stalled = out_ready && stall;
      held = {pixel_out, sof, eol, eof};
      tick();
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;

    check({tag, "_transfers"}, 32'(n), 32'(limit));
    check({tag, "_first_latency"}, 32'(first_rdy - first_rd), 32'(2));
    check({tag, "_no_early_done"}, 32'(done_cnt), 32'(0));
    if (mode == 1) check({tag, "_stall_len"}, 32'(stall_cnt), 32'(5));
    if (mode == 3) check({tag, "_extra_start"}, 32'(start_sent), 32'(1));

    if (mode != 4) begin
      check({tag, "_done_pulse"}, 32'({done, busy, out_ready}), 32'(3'b100));
      start = start_in_done;
      tick();
      start = 1'b0;
      check({tag, "_done_cleared"}, 32'({done, busy}), 32'(0));
      if (start_in_done) begin
        tick();
        check({tag, "_start_in_done_ignored"}, 32'({busy, mem_rd, done}), 32'(0));
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    seed_val = $urandom(32'h5EED1234);
    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          32'({mem_rd, mem_addr, pixel_out, out_ready, sof, eol, eof, busy, done}), 32'(0));
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'({busy, done, mem_rd}), 32'(0));

    run_frame(0, 1'b0, "nominal");
    run_frame(0, 1'b1, "back_to_back");
    run_frame(1, 1'b0, "backpressure");
    run_frame(2, 1'b0, "random_stall");
    run_frame(3, 1'b0, "start_in_run");
    run_frame(4, 1'b0, "abort");

    // Short asynchronous reset mid-frame; data returning afterwards is dropped
    rst = 1'b1;
    #1;
    check("abort_reset_outputs",
          32'({mem_rd, mem_addr, pixel_out, out_ready, sof, eol, eof, busy, done}), 32'(0));
    #2;
    rst = 1'b0;
    tick();
    check("abort_stale_data_dropped", 32'({out_ready, busy, done}), 32'(0));
    tick();
    check("abort_no_done", 32'({out_ready, busy, done, mem_rd}), 32'(0));

    run_frame(0, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
